// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit and the BTB:
// prediction entry layout, FSM encoding, PC step.
package branch_resolve_unit_pkg;

  localparam int ENTRY_W = 65;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } pred_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [31:0] fallthru(
    input logic [31:0] pc
  );
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order queue of fetch-time predictions.
// Clear empties it in one cycle and beats push/pop.
module pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  logic  clear,
  input  pred_t din,
  output logic  full,
  output logic  empty,
  output pred_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = pred_t'(mem[rptr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clear) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolve: compares queued predictions with
// outcomes, drives the BTB update port, redirect and flush window.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter bit UPDATE_ALL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PushValid,
  input  logic [31:0] PushPC,
  input  logic [31:0] PushTarget,
  input  logic        PushTaken,
  input  logic        ResolveValid,
  input  logic        ResolveTaken,
  input  logic [31:0] ResolveTarget,
  output logic        Full,
  output logic        Empty,
  output logic        UpdateEnable,
  output logic [31:0] PCUpdate,
  output logic [31:0] PCBranch,
  output logic        BranchTaken,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic        Flushing,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] PerfBranches,
  output logic [31:0] PerfMispredicts
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  state_t        state;
  state_t        state_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;

  pred_t head;
  pred_t din;
  logic  run;
  logic  do_push;
  logic  do_pop;
  logic  miss;

  assign run     = (state == RUN);
  assign do_pop  = run && ResolveValid && !Empty;
  assign do_push = run && PushValid && (!Full || ResolveValid);
  assign din     = '{pc: PushPC, tgt: PushTarget, tk: PushTaken};

  // a target mismatch only matters when the branch was actually taken
  assign miss = do_pop &&
    ((ResolveTaken != head.tk) ||
     (ResolveTaken && (ResolveTarget != head.tgt)));

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (do_push),
    .pop   (do_pop),
    .clear (miss),
    .din   (din),
    .full  (Full),
    .empty (Empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    unique case (state)
      RUN: begin
        if (miss) begin
          state_n = FLUSH;
          fcnt_n  = FW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt == FW'(1)) state_n = RUN;
        else                fcnt_n  = fcnt - FW'(1);
      end
      default: state_n = RUN;
    endcase
  end

  assign Flushing = (state == FLUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      UpdateEnable <= 1'b0;
      Mispredict   <= 1'b0;
      PCUpdate     <= '0;
      PCBranch     <= '0;
      BranchTaken  <= 1'b0;
      RedirectPC   <= '0;
    end else begin
      UpdateEnable <= do_pop && (UPDATE_ALL || miss);
      Mispredict   <= miss;
      if (do_pop) begin
        PCUpdate    <= head.pc;
        PCBranch    <= ResolveTarget;
        BranchTaken <= ResolveTaken;
        RedirectPC  <= ResolveTaken ? ResolveTarget
                                    : fallthru(head.pc);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Overflow        <= 1'b0;
      Underflow       <= 1'b0;
      PerfBranches    <= '0;
      PerfMispredicts <= '0;
    end else begin
      if (run && PushValid && Full && !ResolveValid)
        Overflow <= 1'b1;
      if (run && ResolveValid && Empty)
        Underflow <= 1'b1;
      if (do_pop)
        PerfBranches <= PerfBranches + 32'd1;
      if (miss)
        PerfMispredicts <= PerfMispredicts + 32'd1;
    end
  end

endmodule
